// File: rtl/sc_et_controller.sv
// sc_et_controller: sequences one stochastic-computing bitstream evaluation,
// checking the scaled estimate at every power-of-two length and stopping early
// once two consecutive checkpoints agree within a latched tolerance.
module sc_et_controller #(
  parameter int unsigned TW     = 8,
  parameter int unsigned MIN_LG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [TW:0]                thresh,
  input  logic                       bit_in,
  output logic                       sng_rst,
  output logic                       sng_en,
  output logic                       busy,
  output logic                       done,
  output logic [TW:0]                result,
  output logic [$clog2(TW+1)-1:0]    len_lg,
  output logic                       early
);

  localparam int unsigned CW = TW + 1;
  localparam int unsigned LW = $clog2(TW + 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [CW-1:0]   ones, ones_d;
  logic [CW-1:0]   prev_est, prev_est_d;
  logic            prev_valid, prev_valid_d;
  logic [CW-1:0]   thr, thr_d;
  logic [CW-1:0]   result_d;
  logic [LW-1:0]   len_lg_d;
  logic            early_d;
  logic            sng_rst_d, sng_en_d, busy_d, done_d;

  logic [CW-1:0]   cnt_inc, ones_inc, est, diff;
  logic [LW-1:0]   lg;
  logic            ckpt, last;

  // Checkpoint decode: detect power-of-two lengths and scale ones to full range
  always_comb begin
    cnt_inc  = cnt + CW'(1);
    ones_inc = ones + CW'(bit_in);
    ckpt     = 1'b0;
    lg       = '0;
    for (int unsigned i = MIN_LG; i <= TW; i++) begin
      if (cnt_inc == (CW'(1) << i)) begin
        ckpt = 1'b1;
        lg   = LW'(i);
      end
    end
    est  = ones_inc << (CW'(TW) - CW'(lg));
    diff = (est >= prev_est) ? (est - prev_est) : (prev_est - est);
    last = (cnt_inc == (CW'(1) << TW));
  end

  // Next-state, datapath updates and next output values
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    ones_d       = ones;
    prev_est_d   = prev_est;
    prev_valid_d = prev_valid;
    thr_d        = thr;
    result_d     = result;
    len_lg_d     = len_lg;
    early_d      = early;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d      = INIT;
          thr_d        = thresh;
          cnt_d        = '0;
          ones_d       = '0;
          prev_valid_d = 1'b0;
        end
      end
      INIT: state_d = RUN;
      RUN: begin
        cnt_d  = cnt_inc;
        ones_d = ones_inc;
        if (ckpt) begin
          // A full-length stop reports early=0 even when the tolerance also passes
          if ((prev_valid && (diff <= thr)) || last) begin
            state_d  = DONE;
            result_d = est;
            len_lg_d = lg;
            early_d  = ~last;
          end else begin
            prev_est_d   = est;
            prev_valid_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sng_rst_d = (state_d == INIT);
    sng_en_d  = (state_d == RUN);
    busy_d    = (state_d == INIT) || (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ones       <= '0;
      prev_est   <= '0;
      prev_valid <= 1'b0;
      thr        <= '0;
      result     <= '0;
      len_lg     <= '0;
      early      <= 1'b0;
      sng_rst    <= 1'b0;
      sng_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ones       <= ones_d;
      prev_est   <= prev_est_d;
      prev_valid <= prev_valid_d;
      thr        <= thr_d;
      result     <= result_d;
      len_lg     <= len_lg_d;
      early      <= early_d;
      sng_rst    <= sng_rst_d;
      sng_en     <= sng_en_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_sc_et_controller.sv
// Testbench for sc_et_controller with TW=4, MIN_LG=1: directed vector table,
// reset/extra-start corner sequences, and randomized runs against a reference model.
module tb_sc_et_controller;

  localparam int TW = 4;
  localparam int FULL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [TW:0] thresh;
  logic        bit_in;
  logic        sng_rst, sng_en, busy, done, early;
  logic [TW:0] result;
  logic [2:0]  len_lg;

  int checks = 0;
  int errors = 0;

  sc_et_controller #(.TW(TW), .MIN_LG(1)) dut (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh), .bit_in(bit_in),
    .sng_rst(sng_rst), .sng_en(sng_en), .busy(busy), .done(done),
    .result(result), .len_lg(len_lg), .early(early)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          thr;
    int          e_res;
    int          e_len;
    int          e_early;
    int          e_nbits;
    bit          inj;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: average of ones scaled to 2^TW at each power-of-two length
  task automatic model(input logic [15:0] bits, input int thr,
                       output int res, output int len, output int erl, output int nbits);
    int ones, prev, est, d;
    bit have_prev;
    ones = 0; prev = 0; have_prev = 0;
    res = 0; len = 0; erl = 0; nbits = 0;
    for (int n = 1; n <= FULL; n++) begin
      ones += int'(bits[n-1]);
      if (n >= 2 && ((1 << $clog2(n)) == n)) begin
        est = ones * FULL / n;
        d = (est > prev) ? est - prev : prev - est;
        if ((have_prev && d <= thr) || n == FULL) begin
          res = est; len = $clog2(n); erl = (n < FULL) ? 1 : 0; nbits = n;
          return;
        end
        prev = est; have_prev = 1;
      end
    end
  endtask

  // Runs one evaluation starting in the current (IDLE) negedge slot
  task automatic run_one(input string tag, input logic [15:0] bits, input int thr,
                         input int e_res, input int e_len, input int e_early,
                         input int e_nbits, input bit inj, input int prev_res);
    int en_cnt, rst_cnt, done_cnt, done_c, g_res, g_len, g_early;
    bit hold_bad, overlap, busy_bad;
    en_cnt = 0; rst_cnt = 0; done_cnt = 0; done_c = -1;
    g_res = -1; g_len = -1; g_early = -1;
    hold_bad = 0; overlap = 0; busy_bad = 0;
    start = 1'b1; thresh = 5'(thr); bit_in = 1'b0;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      @(negedge clk);
      start = (inj && c == 4) ? 1'b1 : 1'b0;
      if (sng_rst) rst_cnt++;
      if (sng_rst && sng_en) overlap = 1;
      if (done) begin
        done_c = c; done_cnt++;
        g_res = int'(result); g_len = int'(len_lg); g_early = int'(early);
        if (busy) busy_bad = 1;
        if (inj) start = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad = 1;
        if (int'(result) != prev_res) hold_bad = 1;
      end
      if (sng_en) begin
        bit_in = (en_cnt < FULL) ? bits[en_cnt] : 1'b0;
        en_cnt++;
      end
    end
    chk({tag, " done_seen"}, (done_c > 0) ? 1 : 0, 1);
    @(negedge clk);
    start = 1'b0;
    if (done) done_cnt++;
    chk({tag, " idle_after"}, int'({busy, sng_en, sng_rst}), 0);
    chk({tag, " result"}, g_res, e_res);
    chk({tag, " len_lg"}, g_len, e_len);
    chk({tag, " early"}, g_early, e_early);
    chk({tag, " done_latency"}, done_c, e_nbits + 2);
    chk({tag, " sng_en_cycles"}, en_cnt, e_nbits);
    chk({tag, " sng_rst_pulses"}, rst_cnt, 1);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " rst_en_overlap"}, int'(overlap), 0);
    chk({tag, " busy_profile"}, int'(busy_bad), 0);
    chk({tag, " result_hold"}, int'(hold_bad), 0);
  endtask

  initial begin
    int prev_res, r_res, r_len, r_erl, r_n, r_thr;
    bit bad;
    logic [15:0] r_bits;

    vecs[0] = '{16'hFFFF, 0, 16, 2, 1, 4,  1'b0};
    vecs[1] = '{16'hFFFF, 5, 16, 2, 1, 4,  1'b0};
    vecs[2] = '{16'h5555, 0,  8, 2, 1, 4,  1'b0};
    vecs[3] = '{16'h0003, 0,  2, 4, 0, 16, 1'b1};
    vecs[4] = '{16'h0003, 4,  4, 3, 1, 8,  1'b0};
    vecs[5] = '{16'h0000, 0,  0, 2, 1, 4,  1'b0};
    vecs[6] = '{16'h0003, 2,  2, 4, 0, 16, 1'b0};

    rst = 1'b1; start = 1'b0; thresh = '0; bit_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({sng_rst, sng_en, busy, done, result, len_lg, early}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", int'({busy, done, sng_en}), 0);

    // Directed table, back-to-back with no idle gap between runs
    prev_res = 0;
    for (int i = 0; i < 7; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].bits, vecs[i].thr, vecs[i].e_res,
              vecs[i].e_len, vecs[i].e_early, vecs[i].e_nbits, vecs[i].inj, prev_res);
      prev_res = vecs[i].e_res;
    end

    // Reset in the middle of a run aborts without a done pulse
    start = 1'b1; thresh = '0; bit_in = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", int'({sng_rst, sng_en, busy, done, result, len_lg, early}), 0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || sng_en || sng_rst) bad = 1;
    end
    chk("post_reset_quiet", int'(bad), 0);
    run_one("after_reset", 16'h0003, 4, 4, 3, 1, 8, 1'b0, 0);
    prev_res = 4;

    // Randomized runs against the reference model
    for (int i = 0; i < 40; i++) begin
      r_bits = 16'($urandom);
      case (i % 4)
        0: r_bits = r_bits & 16'($urandom);
        1: r_bits = r_bits | 16'($urandom);
        default: ;
      endcase
      r_thr = int'($urandom_range(0, 16));
      model(r_bits, r_thr, r_res, r_len, r_erl, r_n);
      run_one($sformatf("rnd%0d", i), r_bits, r_thr, r_res, r_len, r_erl, r_n,
              (i % 5 == 0) ? 1'b1 : 1'b0, prev_res);
      prev_res = r_res;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_et_controller.md
Name: sc_et_controller

Overview:
- Sequences one stochastic-computing (SC) bitstream evaluation with early termination.
- On `start`, it pulses a stream-generator reset, enables the stream generators/datapath, and counts output ones.
- At every power-of-two stream length it compares the scaled estimate against the previous checkpoint's estimate. It terminates once they agree within a threshold, or at full length 2^TW.
- Sits between the top-level sequencer and the SC datapath; replaces free-running power-of-two checkpoint pulsing with a closed-loop termination decision.

Parameters:
- TW, 8: log2 of maximum stream length; full length is 2^TW bits. Legal range 2..16.
- MIN_LG, 1: log2 of the first checkpoint length. Legal range 1..TW-1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin evaluation; honoured only in IDLE.
- thresh  input  TW+1  termination tolerance in full-scale units; latched on accepted start.
- bit_in  input  1  SC datapath output bit; sampled on every rising edge where sng_en=1.
- sng_rst  output  1  one-cycle pulse clearing the stream generators (LFSR seeds) before a run.
- sng_en  output  1  advance stream generators/datapath by one bit this cycle.
- busy  output  1  high in INIT and RUN.
- done  output  1  one-cycle pulse; result, len_lg and early are valid from this cycle.
- result  output  TW+1  full-scale estimate, range 0..2^TW.
- len_lg  output  $clog2(TW+1)  log2 of the stream length actually used.
- early  output  1  1 if the run terminated before 2^TW bits.

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0: sng_rst, sng_en, busy, done, result, len_lg, early.
  - Internal cnt, ones, prev_est, prev_valid cleared.
- Reset mid-run: abort on the next edge; no done pulse; return to IDLE with all outputs 0.
- States and transitions:
  - IDLE: start=1 → INIT. Latch thresh. Clear cnt, ones, prev_valid. result/len_lg/early hold their last values.
  - INIT (exactly 1 cycle): sng_rst=1, sng_en=0, busy=1 → RUN.
  - RUN: sng_en=1, busy=1.
    - Each edge: cnt_n=cnt+1 and ones_n=ones+bit_in. Both are TW+1 bits, never overflow.
    - Checkpoint when cnt_n is a power of two with lg=log2(cnt_n) ≥ MIN_LG.
    - At a checkpoint: est = ones_n << (TW-lg), TW+1 bits, exact.
    - Terminate if prev_valid and |est-prev_est| ≤ thresh, using unsigned absolute difference.
    - Also terminate if cnt_n = 2^TW. If this coincides with a threshold pass, early=0.
    - On terminate: register result=est, len_lg=lg, early=(lg<TW); → DONE.
    - Otherwise at a checkpoint: prev_est=est, prev_valid=1; stay in RUN.
  - DONE (exactly 1 cycle): done=1, busy=0, sng_en=0 → IDLE.
- Boundary and timing rules:
  - The first checkpoint (lg=MIN_LG) never terminates; it only seeds prev_est.
  - start is ignored in INIT, RUN and DONE.
  - start asserted in the DONE cycle is ignored; a new start is accepted from IDLE.
- Latency, with start sampled at edge E0:
  - INIT occupies E0..E1.
  - Bit k is sampled at edge E(k+1).
  - A run terminating after k bits has done high in the cycle after edge E(k+1). A full run gives done in cycle E(2^TW+1)..E(2^TW+2).
- sng_en is never high in the same cycle as sng_rst.
- Exactly one done pulse per accepted start.

Test Plan:
All scenarios use TW=4, MIN_LG=1.
- bit_in=1 constantly, thresh=0:
  - est 16 at n=2 and 16 at n=4 → terminate after 4 bits.
  - Expect result=16, len_lg=2, early=1, done 6 cycles after the start edge, sng_en high for exactly 4 cycles.
- bit_in = 1,0,1,0…, thresh=0:
  - est 8 at n=2 and 8 at n=4.
  - Expect result=8, len_lg=2, early=1.
- bit_in = 1,1 then all 0, thresh=0:
  - est 16, 8, 4, 2 at n=2, 4, 8, 16 → full run.
  - Expect result=2, len_lg=4, early=0, sng_en high for exactly 16 cycles, one done pulse.
- Same stream as the previous scenario, thresh=4:
  - |8-16|=8 fails at n=4; |4-8|=4 passes at n=8.
  - Expect result=4, len_lg=3, early=1.
- Pulse start during RUN and during DONE; assert rst mid-RUN:
  - Extra starts have no effect.
  - rst → IDLE next edge, all outputs 0, no done pulse.
  - A fresh start afterwards shows a single-cycle sng_rst pulse followed by a correct run.
- Back-to-back runs: start in IDLE immediately after done with a different thresh.
  - The new thresh is used, prev_valid is cleared (first checkpoint does not terminate), and the previous result is held until the new done.
